// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    localparam int FIFO_DATA_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF      = 16;

    // Occupancy counter width: one extra bit so that a completely full FIFO (DEPTH) is representable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_param: one write port and one registered read port.
// The array itself is never cleared; only the read register returns to zero on rst.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
    parameter int DEPTH      = FIFO_DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: store wdata at waddr when enabled.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: load the addressed entry on an enabled read; hold it otherwise.
    always_ff @(posedge clock) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty flags
// and one-cycle overflow/underflow pulses.
// Optional build macro SYNC_FIFO_FLUSH_EN adds a 'flush' input that empties the FIFO
// like rst does, but leaves data_out untouched.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
    parameter int DEPTH      = FIFO_DEPTH_DEF,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                         clock,
    input  logic                         rst,
`ifdef SYNC_FIFO_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         wr,
    input  logic                         rd,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic [fifo_cnt_w(DEPTH)-1:0] count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fifo_cnt_w(DEPTH);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (AF_THRESH < 0) || (AF_THRESH > DEPTH) ||
        (AE_THRESH < 0) || (AE_THRESH > DEPTH)) begin : g_bad_params
        $error("sync_fifo_param: DEPTH must be a power of two >= 2 and thresholds within 0..DEPTH");
    end

    logic          clear;
    logic          wr_ok;
    logic          rd_ok;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // flush empties the FIFO but, unlike rst, does not touch the read register.
`ifdef SYNC_FIFO_FLUSH_EN
    assign clear = rst || flush;
`else
    assign clear = rst;
`endif

    // A read frees the head slot in the same edge, so a full FIFO still accepts wr alongside rd.
    assign rd_ok = rd && !empty && !clear;
    assign wr_ok = wr && (!full || rd_ok) && !clear;

    assign empty        = (count == '0);
    assign full         = (count == CNT_FULL);
    assign almost_empty = (count <= CNT_AE);
    assign almost_full  = (count >= CNT_AF);

    // Pointer, occupancy and error-pulse state; rejected requests only raise a pulse.
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            overflow  <= wr && !wr_ok;
            underflow <= rd && !rd_ok;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clock (clock),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous single-clock FIFO. It is the next-generation replacement for the fixed 8-bit/16-entry FIFO.
- Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses.
- Sits between producer and consumer blocks in the same clock domain and is driven by the existing fifo_if-style bench.

Parameters:
DATA_WIDTH, 8, bits per entry (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH

Ports:
clock  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
wr  input  1  write request
rd  input  1  read request
data_in  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  registered read data
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_empty  output  1  count <= AE_THRESH
almost_full  output  1  count >= AF_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset: one clock with rst=1, sampled at the rising edge, has the following effect.
  - Pointers and count go to 0; data_out goes to 0.
  - Flags: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0), overflow=0, underflow=0.
  - Memory contents are not cleared.
  - rst has priority over wr/rd in the same cycle. Reset mid-operation discards all stored data.
- Pointers: write pointer and read pointer are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count and flags: count is a separate register. empty/full/almost_* are decoded from the registered count, so they are valid the cycle after the causing edge.
- Write accept (wr_ok): wr && (!full || rd_ok).
  - data_in is stored at the write pointer and the pointer increments.
- Read accept (rd_ok): rd && !empty.
  - The head entry is loaded into data_out on that edge, so data is visible one cycle after rd is sampled.
  - data_out holds its value when no read is accepted.
- Simultaneous events:
  - wr && rd while full: both accepted, count unchanged.
  - wr && rd while empty: write accepted, read rejected (underflow pulse), count becomes 1.
  - wr && rd otherwise: both accepted, count unchanged.
- Count update: +1 on write only, -1 on read only, unchanged otherwise. The arithmetic never leaves 0..DEPTH.
- Error pulses:
  - overflow = 1 for exactly one cycle after an edge with wr && !wr_ok.
  - underflow = 1 for exactly one cycle after an edge with rd && !rd_ok.
  - The FIFO state is untouched by rejected requests.
- No bypass: data written at edge N is readable (rd accepted) at edge N+1 at the earliest.
- Parameter check: an elaboration-time assertion fires if DEPTH is not a power of two, or if AF_THRESH or AE_THRESH exceeds DEPTH.

Optional Feature:
- Macro: SYNC_FIFO_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 at an edge resets pointers, count and flags exactly as rst does, but data_out retains its value.
  - Priority order: rst > flush > wr/rd.
  - wr/rd in the flush cycle are ignored and raise no error pulse.
- Undefined: no flush port; only rst clears the FIFO.

Decomposition:
- Package sync_fifo_pkg holds:
  - default constants FIFO_DATA_WIDTH_DEF=8 and FIFO_DEPTH_DEF=16;
  - a function fifo_cnt_w(depth) returning $clog2(depth)+1.
- One sub-module, sync_fifo_mem: a simple dual-port register array with one write port, one synchronous read port, and parameters DATA_WIDTH and DEPTH.
- The top module owns pointers, count, flags and the error logic.

Test Plan:
- Reset then idle: after rst, check empty=1, almost_empty=1, count=0, data_out=0; a rd in this state gives underflow=1 for one cycle and count stays 0.
- Fill to full (DEPTH=16): write 0x00..0x0F.
  - almost_full asserts when count=14; full asserts when count=16.
  - A 17th wr (0xAA) gives overflow=1 for one cycle, count stays 16, and 0xAA is never read back.
- Drain: read 16 times and check data_out = 0x00..0x0F in order, each value one cycle after its rd.
  - almost_empty asserts when count=2; empty asserts when count=0.
- Wrap-around: run 40 interleaved writes/reads with random data and random rd/wr gaps; check the full sequence matches a scoreboard queue and count always equals the queue size.
- Simultaneous boundaries:
  - wr+rd while full → count stays 16, no error pulse, oldest entry output.
  - wr+rd while empty → underflow pulse, count=1.
- Mid-operation reset, and flush if SYNC_FIFO_FLUSH_EN is defined:
  - With count=5, assert rst (or flush) for one cycle → count=0 and empty=1.
  - data_out=0 after rst; data_out unchanged after flush.
  - A subsequent write then read of 0x5A returns 0x5A.
